alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 16 +
 rtl/alu_arbiter_rr_arb2.sv | 33 +++
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and widths for the two-requester ALU arbiter.
// FSM encoding plus operand/opcode/counter widths.
package alu_arbiter_pkg;

    localparam int NREQ = 2;
    localparam int DW   = 8;
    localparam int SW   = 4;
    localparam int CW   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant; the pointer names the winner of a tie
// and moves to the losing side whenever a grant is taken.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       take,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one external combinational ALU and
// returns the captured result with the owner's index.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0][DW-1:0]  req_a,
    input  logic [NREQ-1:0][DW-1:0]  req_b,
    input  logic [NREQ-1:0][SW-1:0]  req_sel,
    output logic [DW-1:0]            alu_a,
    output logic [DW-1:0]            alu_b,
    output logic [SW-1:0]            alu_sel,
    input  logic [DW-1:0]            alu_out,
    input  logic                     alu_carryout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_carry,
    output logic                     rsp_id,
    output logic                     busy,
    output logic [CW-1:0]            op_count
);

    localparam logic [1:0] LASTW = 2'(ALU_LAT - 1);

    state_t     state;
    logic [1:0] grant;
    logic [1:0] wcnt;
    logic       owner;
    logic       hs;

    assign req_ready = (state == IDLE) ? grant : 2'b00;
    assign hs        = |(req_valid & req_ready);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (req_valid),
        .take  (hs),
        .grant (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            owner     <= 1'b0;
            wcnt      <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= 1'b0;
            op_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        owner   <= grant[1];
                        alu_a   <= req_a[grant[1]];
                        alu_b   <= req_b[grant[1]];
                        alu_sel <= req_sel[grant[1]];
                        wcnt    <= '0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // alu_* stay put; result is sampled on the last wait cycle
                    if (wcnt == LASTW) begin
                        rsp_data  <= alu_out;
                        rsp_carry <= alu_carryout;
                        rsp_id    <= owner;
                        wcnt      <= '0;
                        state     <= RESP;
                    end else begin
                        wcnt <= wcnt + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count <= op_count + CW'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a stub adder ALU.
// Second instance exercises ALU_LAT=3 and the full opcode range.
module tb_alu_arbiter;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][7:0]  req_a;
    logic [1:0][7:0]  req_b;
    logic [1:0][3:0]  req_sel;
    logic [7:0]       alu_a, alu_b, alu_out;
    logic [3:0]       alu_sel;
    logic             alu_carryout;
    logic             rsp_valid, rsp_ready, rsp_carry, rsp_id, busy;
    logic [7:0]       rsp_data;
    logic [15:0]      op_count;

    logic [1:0]       r3_valid;
    logic [1:0]       r3_ready;
    logic [1:0][7:0]  r3_a;
    logic [1:0][7:0]  r3_b;
    logic [1:0][3:0]  r3_sel;
    logic [7:0]       a3, b3, o3;
    logic [3:0]       s3;
    logic             c3;
    logic             v3, rr3, rc3, id3, busy3;
    logic [7:0]       d3;
    logic [15:0]      cnt3;

    integer checks = 0;
    integer errors = 0;
    int     mptr = 0;
    int     mcount = 0;

    always #5 clk = ~clk;

    assign {alu_carryout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
    assign {c3, o3} = {1'b0, a3} + {1'b0, b3};

    alu_arbiter #(.ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carryout(alu_carryout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r3_valid), .req_ready(r3_ready),
        .req_a(r3_a), .req_b(r3_b), .req_sel(r3_sel),
        .alu_a(a3), .alu_b(b3), .alu_sel(s3),
        .alu_out(o3), .alu_carryout(c3),
        .rsp_valid(v3), .rsp_ready(rr3),
        .rsp_data(d3), .rsp_carry(rc3), .rsp_id(id3),
        .busy(busy3), .op_count(cnt3)
    );

    // Drive one request and walk it to completion; returns observations only.
    task automatic issue(
        input  logic [1:0] v,
        input  logic [7:0] a0, input logic [7:0] b0, input logic [3:0] s0,
        input  logic [7:0] a1, input logic [7:0] b1, input logic [3:0] s1,
        input  int stall,
        output logic [1:0] gnt, output int lat,
        output logic [7:0] d, output logic c, output logic id,
        output logic held, output logic to);
        logic [7:0] d0;
        int n;
        to = 1'b0; held = 1'b1; gnt = 2'b00; lat = 0;
        d = 8'h00; c = 1'b0; id = 1'b0;
        req_valid = v;
        req_a[0] = a0; req_b[0] = b0; req_sel[0] = s0;
        req_a[1] = a1; req_b[1] = b1; req_sel[1] = s1;
        rsp_ready = 1'b0;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            @(posedge clk); #2; n++;
        end
        if (req_ready == 2'b00) begin
            to = 1'b1; req_valid = 2'b00; return;
        end
        gnt = req_ready;
        do begin
            @(posedge clk); #1; lat++;
            if (req_ready != 2'b00) held = 1'b0;
            if (!rsp_valid && alu_sel !== (gnt[1] ? s1 : s0)) held = 1'b0;
        end while (!rsp_valid && lat < 10);
        if (!rsp_valid) begin
            to = 1'b1; req_valid = 2'b00; return;
        end
        d0 = rsp_data;
        repeat (stall) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== d0 || req_ready != 2'b00 || !busy)
                held = 1'b0;
        end
        d = rsp_data; c = rsp_carry; id = rsp_id;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 2'b00;
    endtask

    task automatic test_reset();
        req_valid = 2'b00; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sel = '0;
        r3_valid = 2'b00; rr3 = 1'b0;
        r3_a = '0; r3_b = '0; r3_sel = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, alu_a, alu_b, alu_sel, rsp_data,
             rsp_carry, rsp_id, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rsp_valid=%b op_count=%h alu_a=%h want all zero",
                     busy, rsp_valid, op_count, alu_a);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mptr = 0; mcount = 0;
    endtask

    task automatic test_single();
        logic [1:0] g; int lat; logic [7:0] d; logic c, id, held, to;
        issue(2'b01, 8'h0A, 8'h0B, 4'h1, 8'h00, 8'h00, 4'h0, 0,
              g, lat, d, c, id, held, to);
        mcount++; mptr = 1;
        checks++;
        if (to || g !== 2'b01 || lat != 2) begin
            errors++;
            $display("FAIL single0_timing: grant=%b lat=%0d to=%b want 01/2/0", g, lat, to);
        end
        checks++;
        if (d !== 8'h15 || c !== 1'b0 || id !== 1'b0 || op_count !== 16'(mcount)) begin
            errors++;
            $display("FAIL single0_result: data=%h carry=%b id=%b cnt=%0d want 15/0/0/%0d",
                     d, c, id, op_count, mcount);
        end
        issue(2'b10, 8'h00, 8'h00, 4'h0, 8'hF6, 8'h0A, 4'h2, 0,
              g, lat, d, c, id, held, to);
        mcount++; mptr = 0;
        checks++;
        if (to || g !== 2'b10 || d !== 8'h00 || c !== 1'b1 || id !== 1'b1) begin
            errors++;
            $display("FAIL single1_result: grant=%b data=%h carry=%b id=%b want 10/00/1/1",
                     g, d, c, id);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] g; int lat; logic [7:0] d; logic c, id, held, to;
        logic [1:0] want;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            issue(2'b11, 8'(i), 8'h10, 4'h3, 8'(i + 8'h40), 8'h20, 4'h4, 0,
                  g, lat, d, c, id, held, to);
            mcount++;
            mptr = (want == 2'b01) ? 1 : 0;
            checks++;
            if (to || g !== want || id !== want[1] || !held) begin
                errors++;
                $display("FAIL rr_grant%0d: grant=%b id=%b held=%b want %b/%b/1",
                         i, g, id, held, want, want[1]);
            end
        end
        checks++;
        if (op_count !== 16'(mcount)) begin
            errors++;
            $display("FAIL rr_count: got %0d want %0d", op_count, mcount);
        end
    endtask

    task automatic test_stall();
        logic [1:0] g; int lat; logic [7:0] d; logic c, id, held, to;
        issue(2'b11, 8'h33, 8'h44, 4'h7, 8'h55, 8'h66, 4'h8, 5,
              g, lat, d, c, id, held, to);
        mcount++;
        checks++;
        if (to || !held || g !== 2'b01 || d !== 8'h77) begin
            errors++;
            $display("FAIL stall_hold: held=%b grant=%b data=%h want 1/01/77", held, g, d);
        end
        mptr = 1;
        checks++;
        if (op_count !== 16'(mcount) || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_count: cnt=%0d busy=%b want %0d/0", op_count, busy, mcount);
        end
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (op_count !== 16'(mcount) || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_rsp_ready: cnt=%0d rsp_valid=%b want %0d/0",
                     op_count, rsp_valid, mcount);
        end
    endtask

    task automatic test_random();
        logic [1:0] g; int lat; logic [7:0] d; logic c, id, held, to;
        logic [1:0] v; logic [7:0] a0, b0, a1, b1; logic [3:0] s0, s1;
        int owner, st, sum;
        for (int i = 0; i < 24; i++) begin
            v = 2'($urandom_range(1, 3));
            a0 = 8'($urandom); b0 = 8'($urandom); s0 = 4'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); s1 = 4'($urandom);
            st = $urandom_range(0, 3);
            owner = (v == 2'b11) ? mptr : ((v == 2'b10) ? 1 : 0);
            sum = (owner == 1) ? (int'(a1) + int'(b1)) : (int'(a0) + int'(b0));
            issue(v, a0, b0, s0, a1, b1, s1, st, g, lat, d, c, id, held, to);
            mptr = 1 - owner;
            mcount++;
            checks++;
            if (to || g !== 2'(1 << owner) || lat != 2 || !held || id !== 1'(owner)
                || d !== 8'(sum % 256) || c !== 1'(sum / 256)
                || op_count !== 16'(mcount)) begin
                errors++;
                $display("FAIL random%0d: grant=%b lat=%0d id=%b data=%h carry=%b cnt=%0d want owner=%0d data=%h carry=%0d cnt=%0d",
                         i, g, lat, id, d, c, op_count, owner, 8'(sum % 256), sum / 256, mcount);
            end
        end
    endtask

    task automatic test_reset_exec();
        logic [1:0] g; int lat; logic [7:0] d; logic c, id, held, to;
        logic seen;
        issue(2'b10, 8'h00, 8'h00, 4'h0, 8'h01, 8'h02, 4'h5, 0,
              g, lat, d, c, id, held, to);
        mptr = 0;
        req_valid = 2'b10; req_a[1] = 8'h9C; req_b[1] = 8'h11; req_sel[1] = 4'hA;
        @(posedge clk); #1;
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1 || alu_sel !== 4'hA) begin
            errors++;
            $display("FAIL exec_before_reset: busy=%b alu_sel=%h want 1/a", busy, alu_sel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, rsp_valid, req_ready, alu_a, alu_b, alu_sel, op_count} !== '0) begin
            errors++;
            $display("FAIL reset_in_exec: busy=%b alu_a=%h alu_sel=%h cnt=%0d want zeros",
                     busy, alu_a, alu_sel, op_count);
        end
        @(negedge clk) rst_n = 1'b1;
        mptr = 0; mcount = 0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen || op_count !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abort: rsp_seen=%b cnt=%0d want 0/0", seen, op_count);
        end
        issue(2'b11, 8'h01, 8'h01, 4'h0, 8'h02, 8'h02, 4'h0, 0,
              g, lat, d, c, id, held, to);
        mcount++; mptr = 1;
        checks++;
        if (to || g !== 2'b01 || d !== 8'h02 || op_count !== 16'(mcount)) begin
            errors++;
            $display("FAIL ptr_after_reset: grant=%b data=%h cnt=%0d want 01/02/%0d",
                     g, d, op_count, mcount);
        end
    endtask

    task automatic test_lat3();
        int lat, sum;
        logic selok;
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            r3_valid = 2'b01;
            r3_a[0] = 8'($urandom); r3_b[0] = 8'($urandom); r3_sel[0] = 4'(i);
            rr3 = 1'b1;
            sum = int'(r3_a[0]) + int'(r3_b[0]);
            #1;
            if (r3_ready !== 2'b01) begin
                bad++;
                $display("FAIL lat3_grant%0d: ready=%b want 01", i, r3_ready);
            end
            lat = 0; selok = 1'b1;
            do begin
                @(posedge clk); #1; lat++;
                if (!v3 && s3 !== 4'(i)) selok = 1'b0;
            end while (!v3 && lat < 10);
            r3_valid = 2'b00;
            if (lat != 4 || !selok || d3 !== 8'(sum % 256) || rc3 !== 1'(sum / 256)) begin
                bad++;
                $display("FAIL lat3_op%0d: lat=%0d selok=%b data=%h want 4/1/%h",
                         i, lat, selok, d3, 8'(sum % 256));
            end
            @(posedge clk); #1;
        end
        rr3 = 1'b0;
        checks++;
        if (bad != 0 || cnt3 !== 16'd16) begin
            errors++;
            $display("FAIL lat3_sweep: bad=%0d cnt=%0d want 0/16", bad, cnt3);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_lat3();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
